// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Time-setting controller for the sec/min/hour clock core. Three push buttons
// drive a set-mode state machine that edits a shadow copy of the time. The
// edited time is committed to the core through a one-cycle-per-field load
// burst (hours, then minutes, then seconds). The core's count enable is held
// low from entry into set mode until the burst has finished.
//
// Parameters
//   BLINK_DIV   clock cycles per half-period of blink
//   DEB_CYCLES  debounce stability window in cycles (debounce build only)
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   btn_mode   in   async button: enter set mode / next field / commit
//   btn_inc    in   async button: increment selected field
//   btn_dec    in   async button: decrement selected field
//   sec        in   [5:0] current seconds from the core
//   min        in   [5:0] current minutes from the core
//   hour       in   [4:0] current hours from the core
//   data1      out  [5:0] seconds load value
//   data2      out  [5:0] minutes load value
//   data3      out  [5:0] hours load value, {1'b0, shadow hour}
//   load1/2/3  out  one-cycle load strobes for seconds / minutes / hours
//   enable     out  core count enable
//   set_field  out  [1:0] field being edited: 0 none, 1 hour, 2 min, 3 sec
//   blink      out  display blink square wave
//
// Build option
//   CLKSET_DEBOUNCE_EN  when defined, each synchronized button passes through
//                       a counter debouncer before edge detection.
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int BLINK_DIV  = 25_000_000,
    parameter int DEB_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hour,
    output logic [5:0] data1,
    output logic [5:0] data2,
    output logic [5:0] data3,
    output logic       load1,
    output logic       load2,
    output logic       load3,
    output logic       enable,
    output logic [1:0] set_field,
    output logic       blink
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_SET_H = 3'd1,
        ST_SET_M = 3'd2,
        ST_SET_S = 3'd3,
        ST_LD_H  = 3'd4,
        ST_LD_M  = 3'd5,
        ST_LD_S  = 3'd6
    } state_e;

    localparam int BLINK_W = $clog2(BLINK_DIV + 1);

    if (BLINK_DIV < 1 || DEB_CYCLES < 1) begin : g_bad_param
        $error("clock_set_ctrl: BLINK_DIV and DEB_CYCLES must be >= 1");
    end

    // -------------------------------------------------------------------------
    // Button conditioning: 2-flop synchronizer, optional debouncer, rising edge
    // -------------------------------------------------------------------------
    logic [2:0] btn_raw;
    logic [2:0] sync1_q;
    logic [2:0] sync2_q;
    logic [2:0] btn_lvl;
    logic [2:0] prev_q;
    logic [2:0] btn_pulse;

    assign btn_raw = {btn_dec, btn_inc, btn_mode};

    // NOTE: reset is sampled inside the clocked block (synchronous), and every
    // flop is updated with <= so all registers see the pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= btn_lvl;
        end
    end

`ifdef CLKSET_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [2:0]            filt_q;
    logic [2:0][DEB_W-1:0] deb_cnt_q;

    // The filtered level follows the synced level only after it has differed
    // for DEB_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            filt_q    <= '0;
            deb_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != filt_q[i]) begin
                    if (deb_cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        filt_q[i]    <= sync2_q[i];
                        deb_cnt_q[i] <= '0;
                    end else begin
                        deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                    end
                end else begin
                    deb_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign btn_lvl = filt_q;
`else
    assign btn_lvl = sync2_q;
`endif

    assign btn_pulse = btn_lvl & ~prev_q;

    logic mode_p;
    logic inc_p;
    logic dec_p;
    logic edit_inc;
    logic edit_dec;

    assign mode_p = btn_pulse[0];
    assign inc_p  = btn_pulse[1];
    assign dec_p  = btn_pulse[2];

    // Mode outranks edits; inc together with dec cancels out.
    assign edit_inc = inc_p & ~dec_p & ~mode_p;
    assign edit_dec = dec_p & ~inc_p & ~mode_p;

    // -------------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // -------------------------------------------------------------------------
    state_e state_q;
    state_e state_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (mode_p) state_d = ST_SET_H;
            ST_SET_H: if (mode_p) state_d = ST_SET_M;
            ST_SET_M: if (mode_p) state_d = ST_SET_S;
            ST_SET_S: if (mode_p) state_d = ST_LD_H;
            ST_LD_H:  state_d = ST_LD_M;
            ST_LD_M:  state_d = ST_LD_S;
            ST_LD_S:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        enable    = 1'b0;
        set_field = 2'd0;
        load1     = 1'b0;
        load2     = 1'b0;
        load3     = 1'b0;
        case (state_q)
            ST_RUN:   enable    = 1'b1;
            ST_SET_H: set_field = 2'd1;
            ST_SET_M: set_field = 2'd2;
            ST_SET_S: set_field = 2'd3;
            ST_LD_H:  load3     = 1'b1;
            ST_LD_M:  load2     = 1'b1;
            ST_LD_S:  load1     = 1'b1;
            default:  enable    = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // Shadow time and load data
    // -------------------------------------------------------------------------
    // Steps a field within 0..top with wrap-around. A value already above top
    // (captured from a misbehaving core) snaps to 0 on its first edit.
    function automatic logic [5:0] step_field(input logic [5:0] v,
                                              input logic [5:0] top,
                                              input logic       up);
        if (v > top) return 6'd0;
        if (up)      return (v == top) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? top : v - 6'd1;
    endfunction

    logic [4:0] sh_h_q, sh_h_d;
    logic [5:0] sh_m_q, sh_m_d;
    logic [5:0] sh_s_q, sh_s_d;
    logic [4:0] data_h_q;
    logic [5:0] data_m_q;
    logic [5:0] data_s_q;
    logic       edit;

    assign edit = edit_inc | edit_dec;

    always_comb begin
        sh_h_d = sh_h_q;
        sh_m_d = sh_m_q;
        sh_s_d = sh_s_q;
        case (state_q)
            ST_RUN: begin
                if (mode_p) begin
                    sh_h_d = hour;
                    sh_m_d = min;
                    sh_s_d = sec;
                end
            end
            ST_SET_H: if (edit) sh_h_d = 5'(step_field({1'b0, sh_h_q}, 6'd23, edit_inc));
            ST_SET_M: if (edit) sh_m_d = step_field(sh_m_q, 6'd59, edit_inc);
            ST_SET_S: if (edit) sh_s_d = step_field(sh_s_q, 6'd59, edit_inc);
            default: ;
        endcase
    end

    // Load data trails the shadow by one cycle, so it is settled for at least
    // one cycle before any strobe and stays constant through the burst.
    always_ff @(posedge clock) begin
        if (reset) begin
            sh_h_q   <= '0;
            sh_m_q   <= '0;
            sh_s_q   <= '0;
            data_h_q <= '0;
            data_m_q <= '0;
            data_s_q <= '0;
        end else begin
            sh_h_q   <= sh_h_d;
            sh_m_q   <= sh_m_d;
            sh_s_q   <= sh_s_d;
            data_h_q <= sh_h_q;
            data_m_q <= sh_m_q;
            data_s_q <= sh_s_q;
        end
    end

    assign data1 = data_s_q;
    assign data2 = data_m_q;
    assign data3 = {1'b0, data_h_q};

    // -------------------------------------------------------------------------
    // Blink generator; phase restarts when set mode is entered so the first
    // blink period of an edit session is always full length.
    // -------------------------------------------------------------------------
    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_q;
    logic               blink_restart;

    assign blink_restart = (state_q == ST_RUN) && (state_d == ST_SET_H);

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else if (blink_restart) begin
            blink_cnt_q <= '0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign blink = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Self-checking bench for clock_set_ctrl (default build, no debouncer).
// A behavioural model tracks the button pulses from the raw input history,
// the set-mode phase, the shadow time and the blink phase; every cycle all
// outputs are compared against it. Directed sequences cover the documented
// scenarios, followed by randomized button and core-time traffic.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int BDIV = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       btn_dec = 1'b0;
    logic [5:0] sec = '0;
    logic [5:0] min = '0;
    logic [4:0] hour = '0;
    logic [5:0] data1;
    logic [5:0] data2;
    logic [5:0] data3;
    logic       load1;
    logic       load2;
    logic       load3;
    logic       enable;
    logic [1:0] set_field;
    logic       blink;

    clock_set_ctrl #(
        .BLINK_DIV (BDIV),
        .DEB_CYCLES(16)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .btn_dec  (btn_dec),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .data1    (data1),
        .data2    (data2),
        .data3    (data3),
        .load1    (load1),
        .load2    (load2),
        .load3    (load3),
        .enable   (enable),
        .set_field(set_field),
        .blink    (blink)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 run, 1 set hour, 2 set min, 3 set sec, 4/5/6 load h/m/s
    int       ph = 0;
    int       sh[3];      // shadow: [0] hour, [1] min, [2] sec
    int       dat[3];     // load data seen on the outputs
    bit [2:0] hq[3];      // per button: last three sampled levels, [0] newest
    int       bl_base = 0;
    int       bl_edges = 0;

    function automatic int bump(int v, int top, bit up);
        int m = top + 1;
        if (v > top) return 0;
        return up ? (v + 1) % m : (v + m - 1) % m;
    endfunction

    function automatic int exp_blink();
        return bl_base ^ ((bl_edges / BDIV) & 1);
    endfunction

    task automatic model_step();
        bit raw[3];
        bit p[3];
        bit edit_ok;
        int old_ph;
        raw[0] = btn_mode;
        raw[1] = btn_inc;
        raw[2] = btn_dec;
        if (reset) begin
            ph = 0;
            for (int i = 0; i < 3; i++) begin
                sh[i]  = 0;
                dat[i] = 0;
                hq[i]  = '0;
            end
            bl_base  = 0;
            bl_edges = 0;
            return;
        end
        // A press sampled at edge n acts at edge n+2: pulse = level two edges
        // ago and low three edges ago.
        for (int b = 0; b < 3; b++) begin
            p[b]  = hq[b][1] & ~hq[b][2];
            hq[b] = {hq[b][1:0], raw[b]};
        end
        for (int i = 0; i < 3; i++) dat[i] = sh[i];
        old_ph  = ph;
        edit_ok = !p[0] && (p[1] ^ p[2]);
        case (ph)
            0: if (p[0]) begin
                   sh[0] = int'(hour);
                   sh[1] = int'(min);
                   sh[2] = int'(sec);
                   ph = 1;
               end
            1, 2, 3: begin
                if (p[0]) ph = ph + 1;
                else if (edit_ok) sh[ph-1] = bump(sh[ph-1], (ph == 1) ? 23 : 59, p[1]);
            end
            4, 5: ph = ph + 1;
            default: ph = 0;
        endcase
        if (old_ph == 0 && ph == 1) begin
            bl_base  = exp_blink();
            bl_edges = 0;
        end else begin
            bl_edges++;
        end
    endtask

    task automatic check_outputs();
        check("enable",    32'(enable),    32'(ph == 0));
        check("set_field", 32'(set_field), 32'((ph >= 1 && ph <= 3) ? ph : 0));
        check("load3",     32'(load3),     32'(ph == 4));
        check("load2",     32'(load2),     32'(ph == 5));
        check("load1",     32'(load1),     32'(ph == 6));
        check("data3",     32'(data3),     32'(dat[0]));
        check("data2",     32'(data2),     32'(dat[1]));
        check("data1",     32'(data1),     32'(dat[2]));
        check("blink",     32'(blink),     32'(exp_blink()));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
    endtask

    // mask bits: [0] mode, [1] inc, [2] dec. Effect lands on the last tick.
    task automatic press(input logic [2:0] mask);
        {btn_dec, btn_inc, btn_mode} = mask;
        tick();
        {btn_dec, btn_inc, btn_mode} = 3'b000;
        tick();
        tick();
    endtask

    localparam logic [2:0] B_MODE = 3'b001;
    localparam logic [2:0] B_INC  = 3'b010;
    localparam logic [2:0] B_DEC  = 3'b100;

    int       hold[3];
    bit [2:0] lvl;

    initial begin
        // Reset held two cycles
        reset = 1'b1;
        tick();
        check("rst_enable", 32'(enable), 32'd1);
        check("rst_loads",  32'({load3, load2, load1}), 32'd0);
        check("rst_data",   32'({data3, data2, data1}), 32'd0);
        check("rst_field",  32'(set_field), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // 05:29:03 -> edit to 08:59:03 and commit
        hour = 5'd5; min = 6'd29; sec = 6'd3;
        press(B_MODE);
        check("seth_field",  32'(set_field), 32'd1);
        check("seth_enable", 32'(enable), 32'd0);
        repeat (3) press(B_INC);
        press(B_MODE);
        repeat (30) press(B_DEC);
        press(B_MODE);
        press(B_MODE);
        check("burst_load3", 32'(load3), 32'd1);
        check("burst_data3", 32'(data3), 32'd8);
        check("burst_en_h",  32'(enable), 32'd0);
        tick();
        check("burst_load2", 32'(load2), 32'd1);
        check("burst_data2", 32'(data2), 32'd59);
        tick();
        check("burst_load1", 32'(load1), 32'd1);
        check("burst_data1", 32'(data1), 32'd3);
        check("burst_en_s",  32'(enable), 32'd0);
        tick();
        check("burst_done_en", 32'(enable), 32'd1);
        check("burst_done_ld", 32'({load3, load2, load1}), 32'd0);

        // Wrap-around at field limits
        hour = 5'd23; min = 6'd0; sec = 6'd59;
        press(B_MODE);
        press(B_INC);  tick(); check("wrap_h_inc", 32'(data3), 32'd0);
        press(B_DEC);  tick(); check("wrap_h_dec", 32'(data3), 32'd23);
        press(B_MODE);
        press(B_DEC);  tick(); check("wrap_m_dec", 32'(data2), 32'd59);
        press(B_MODE);
        press(B_INC);  tick(); check("wrap_s_inc", 32'(data1), 32'd0);
        press(B_MODE);
        repeat (3) tick();

        // Simultaneous pulses
        hour = 5'd10; min = 6'd20; sec = 6'd30;
        press(B_MODE);
        press(B_MODE | B_INC);
        check("mode_inc_field", 32'(set_field), 32'd2);
        tick();
        check("mode_inc_hour", 32'(data3), 32'd10);
        press(B_INC | B_DEC);
        tick();
        check("inc_dec_min",   32'(data2), 32'd20);
        check("inc_dec_field", 32'(set_field), 32'd2);
        press(B_MODE);
        press(B_MODE);
        repeat (3) tick();

        // Reset while load2 is high aborts the burst
        press(B_MODE);
        press(B_MODE);
        press(B_MODE);
        press(B_MODE);
        tick();
        check("abort_load2", 32'(load2), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_load1", 32'(load1), 32'd0);
        check("abort_en",    32'(enable), 32'd1);
        check("abort_field", 32'(set_field), 32'd0);
        reset = 1'b0;
        tick();

        // Randomized traffic
        for (int i = 0; i < 3; i++) hold[i] = 0;
        lvl = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = ($urandom_range(0, 9) < 3);
                    hold[b] = int'($urandom_range(1, 4));
                end
                hold[b]--;
            end
            {btn_dec, btn_inc, btn_mode} = lvl;
            if ($urandom_range(0, 19) == 0) begin
                hour = 5'($urandom_range(0, 31));
                min  = 6'($urandom_range(0, 63));
                sec  = 6'($urandom_range(0, 63));
            end
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0;
        {btn_dec, btn_inc, btn_mode} = 3'b000;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the `clock` core (sec/min/hour counters with `load1`/`load2`/`load3` and `data1`/`data2`/`data3`). It turns three push-button inputs into a set-mode state machine and edits a shadow copy of the time. It commits the edited time to the core through a sequenced load burst and gates the core's `enable` while setting. It sits between the board buttons and the `clock` instance.

## Interface
- `BLINK_DIV`, default 25_000_000: clock cycles per half-period of `blink`.
- `DEB_CYCLES`, default 16: stability window in cycles, used only when debounce is compiled in.
- `clock`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `btn_mode`  in  1  async button: enter set mode, advance field, commit.
- `btn_inc`  in  1  async button: increment selected field.
- `btn_dec`  in  1  async button: decrement selected field.
- `sec`  in  6  current seconds from core.
- `min`  in  6  current minutes from core.
- `hour`  in  5  current hours from core.
- `data1`  out  6  seconds load value to core.
- `data2`  out  6  minutes load value to core.
- `data3`  out  6  hours load value to core; `{1'b0, shadow_h}`.
- `load1` / `load2` / `load3`  out  1 each  one-cycle load strobes: seconds, minutes, hours.
- `enable`  out  1  core count enable.
- `set_field`  out  2  field being edited: 0 none, 1 hour, 2 min, 3 sec.
- `blink`  out  1  display blink square wave; valid in every state.

## Operation
- Each button: 2-flop synchronizer, then rising-edge detect, giving a one-cycle pulse per press. Holding a button produces no repeats.
- States: RUN, SET_H, SET_M, SET_S, LD_H, LD_M, LD_S.
- RUN:
  - `enable`=1, `set_field`=0.
  - `mode` pulse: copy `sec`/`min`/`hour` into shadow registers `sh_s`/`sh_m`/`sh_h`, then go to SET_H.
  - `inc`/`dec` are ignored.
- SET_H / SET_M / SET_S:
  - `enable`=0, `set_field`=1/2/3.
  - `inc`: selected field +1; `dec`: selected field −1.
  - Hour wraps 23↔0; min and sec wrap 59↔0.
  - `mode` pulse: SET_H→SET_M→SET_S→LD_H.
- LD_H, LD_M, LD_S: one cycle each, in that order.
  - Each asserts only its own strobe: `load3`, then `load2`, then `load1`.
  - `enable`=0 throughout. Next state after LD_S is RUN.
- `data1`/`data2`/`data3` are registered copies of the shadow values and are driven in every state. They are stable for at least one cycle before and during each strobe.
- Simultaneous pulses:
  - `mode` with `inc` or `dec`: mode wins; the edit is dropped.
  - `inc` with `dec`: both are ignored.
- Button pulses arriving in the LD states are discarded.
- Shadow values out of range on capture (core misbehaving) are clamped to 0 on the first edit of that field.

## Timing
- Reset values:
  - state RUN, `enable`=1, all `load*`=0.
  - `data1`=`data2`=`data3`=0, shadows 0, `set_field`=0, `blink`=0, blink counter 0, synchronizer and edge flops 0.
- Button latency, no debounce: a button first sampled high at edge k changes state/shadow at edge k+2; outputs are visible after edge k+2.
- Commit: the `mode` press in SET_S moves to LD_H. Then `load3` is high 1 cycle, `load2` the next, `load1` the next. `enable` returns to 1 in the cycle after `load1`.
- The `enable`=0 window covers the whole load burst, so the core never counts between loads.
- `reset` in any state, including mid-burst, aborts immediately: no further strobes, and the core resumes counting with whatever it already loaded.
- `blink` toggles every `BLINK_DIV` cycles. The counter restarts on entry to SET_H.

## Configuration
- `CLKSET_DEBOUNCE_EN` defined: each synchronized button feeds a counter debouncer. The filtered level changes only after the raw synced level differs from it for `DEB_CYCLES` consecutive cycles, which adds `DEB_CYCLES` cycles to button latency. Glitches shorter than `DEB_CYCLES` produce no pulse.
- Not defined: no debouncer or `DEB_CYCLES` logic. The edge detect runs directly on the synchronizer output.

## Test plan
- Reset, then hold `reset` 2 cycles with all buttons low -> `enable`=1, `load*`=0, `data*`=0, `set_field`=0 after the first edge.
- Core at 05:29:03; press mode, inc hour 3×, mode, dec min 30×, mode, mode -> `load3` with `data3`=8, then `load2` with `data2`=59, then `load1` with `data1`=3 on consecutive cycles; `enable`=0 from SET_H through LD_S, then 1.
- Wrap: hour 23 + inc -> 0; hour 0 + dec -> 23; sec 59 + inc -> 0; min 0 + dec -> 59.
- `mode` and `inc` pulse in the same cycle in SET_H -> state SET_M, hour unchanged. `inc` and `dec` together -> no change.
- Assert `reset` in the cycle `load2` is high -> next cycle `load1`=0, state RUN, `enable`=1.
- With `CLKSET_DEBOUNCE_EN`, `DEB_CYCLES`=16: 10-cycle glitch on `btn_inc` -> no edit; a 20-cycle press -> exactly one increment, 18 cycles after the first sample.
